feedback_peg_drawer: RTL

Parametrised feedback-peg renderer for the Mastermind VGA display. After each scored guess it takes the correct-place and correct-colour counts and draws NUM_PEGS square pegs, one pixel per clock, into the feedback column of the selected guess row. Its x/y/colour/plot outputs drive the VGA adapter's pixel-write port through the display mux. Pegs are drawn black for correct place, white for correct colour, red otherwise. A start/done handshake lets the game controller sequence it after scoring.

---
 rtl/feedback_peg_drawer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/feedback_peg_drawer.sv
// feedback_peg_drawer
// Renders NUM_PEGS square feedback pegs for one guess row, one pixel per
// clock, into the feedback column of the Mastermind VGA display.
// Ports:
//   clk, resetn          clock and synchronous active-low reset
//   start                begin a draw (sampled only while idle)
//   row                  guess row to draw into (latched on start)
//   c_place, c_color     correct-place / correct-colour counts (latched on start)
//   x_out, y_out         registered pixel coordinates
//   color_out            registered pixel RGB (000 black, 111 white, 100 red)
//   plot                 pixel write strobe
//   busy                 high while drawing and in the done cycle
//   done                 one-cycle completion pulse
//   win                  high with done when every peg is in the correct place
module feedback_peg_drawer #(
  parameter int unsigned NUM_PEGS = 4,
  parameter int unsigned PEG_SIZE = 4,
  parameter int unsigned X_BASE   = 128,
  parameter int unsigned X_PITCH  = 5,
  parameter int unsigned Y_BASE   = 8,
  parameter int unsigned Y_PITCH  = 10,
  parameter int unsigned ROW_W    = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [ROW_W-1:0] row,
  input  logic [CNT_W-1:0] c_place,
  input  logic [CNT_W-1:0] c_color,
  output logic [7:0]       x_out,
  output logic [6:0]       y_out,
  output logic [2:0]       color_out,
  output logic             plot,
  output logic             busy,
  output logic             done,
  output logic             win
);

  localparam int unsigned IW = (NUM_PEGS > 1) ? $clog2(NUM_PEGS) : 1;
  localparam int unsigned DW = (PEG_SIZE > 1) ? $clog2(PEG_SIZE) : 1;
  localparam int unsigned PW = 4;   // holds a peg count of 0..8
  localparam int unsigned AW = 16;  // coordinate / clamp arithmetic width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [PW-1:0]    p_q, p_d;
  logic [PW-1:0]    w_q, w_d;
  logic [IW-1:0]    i_q, i_d;
  logic [DW-1:0]    dx_q, dx_d;
  logic [DW-1:0]    dy_q, dy_d;
  logic [7:0]       x_out_q, x_out_d;
  logic [6:0]       y_out_q, y_out_d;
  logic [2:0]       color_out_q, color_out_d;
  logic             plot_q, plot_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             win_q, win_d;

  // Count clamping: p never exceeds NUM_PEGS, p + w never exceeds NUM_PEGS
  logic [AW-1:0] cp_w, cc_w, p_in, w_in, room;

  always_comb begin
    cp_w = AW'(c_place);
    cc_w = AW'(c_color);
    p_in = (cp_w > AW'(NUM_PEGS)) ? AW'(NUM_PEGS) : cp_w;
    room = AW'(NUM_PEGS) - p_in;
    w_in = (cc_w > room) ? room : cc_w;
  end

  logic last_dx, last_dy, last_i;

  always_comb begin
    last_dx = (dx_q == DW'(PEG_SIZE - 1));
    last_dy = (dy_q == DW'(PEG_SIZE - 1));
    last_i  = (i_q == IW'(NUM_PEGS - 1));
  end

  // Control: the counters always index the pixel currently on the outputs
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    p_d     = p_q;
    w_d     = w_q;
    i_d     = i_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    plot_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    win_d   = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d = DRAW;
          row_d   = row;
          p_d     = PW'(p_in);
          w_d     = PW'(w_in);
          i_d     = '0;
          dx_d    = '0;
          dy_d    = '0;
          plot_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      DRAW: begin
        busy_d = 1'b1;
        if (last_i && last_dx && last_dy) begin
          state_d = DONE;
          done_d  = 1'b1;
          win_d   = (p_q == PW'(NUM_PEGS));
        end else begin
          plot_d = 1'b1;
          if (!last_dx) begin
            dx_d = dx_q + DW'(1);
          end else begin
            dx_d = '0;
            if (!last_dy) begin
              dy_d = dy_q + DW'(1);
            end else begin
              dy_d = '0;
              i_d  = i_q + IW'(1);
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Pixel datapath: registers the pixel addressed by the next counter values
  always_comb begin
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;
    color_out_d = color_out_q;
    if (plot_d) begin
      x_out_d = 8'(AW'(X_BASE) + AW'(i_d) * AW'(X_PITCH) + AW'(dx_d));
      y_out_d = 7'(AW'(Y_BASE) + AW'(row_d) * AW'(Y_PITCH) + AW'(dy_d));
      if (AW'(i_d) < AW'(p_d)) begin
        color_out_d = 3'b000;
      end else if (AW'(i_d) < (AW'(p_d) + AW'(w_d))) begin
        color_out_d = 3'b111;
      end else begin
        color_out_d = 3'b100;
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      row_q       <= '0;
      p_q         <= '0;
      w_q         <= '0;
      i_q         <= '0;
      dx_q        <= '0;
      dy_q        <= '0;
      x_out_q     <= '0;
      y_out_q     <= '0;
      color_out_q <= '0;
      plot_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      p_q         <= p_d;
      w_q         <= w_d;
      i_q         <= i_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
      color_out_q <= color_out_d;
      plot_q      <= plot_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      win_q       <= win_d;
    end
  end

  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign color_out = color_out_q;
  assign plot      = plot_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign win       = win_q;

endmodule
